// File: rtl/bp_be_late_wb_queue.sv
`timescale 1ns/1ps
// Late-writeback queue: merges dcache-miss and FP div/sqrt writebacks into one scheduler port.
// Optional same-cycle bypass when empty: define BP_BE_LATE_WB_BYPASS_EN.
module bp_be_late_wb_queue #(
    // Normally sized by bp_be_wb_pkt_width(vaddr_width_p); the payload is opaque here.
    parameter int wb_pkt_width_p = 64,
    parameter int els_p          = 4,
    parameter int force_age_p    = 8
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,

    input  logic                      mem_v_i,
    input  logic [wb_pkt_width_p-1:0] mem_pkt_i,
    output logic                      mem_ready_and_o,

    input  logic                      fpu_v_i,
    input  logic [wb_pkt_width_p-1:0] fpu_pkt_i,
    output logic                      fpu_ready_and_o,

    output logic                      late_wb_v_o,
    output logic [wb_pkt_width_p-1:0] late_wb_pkt_o,
    output logic                      late_wb_force_o,
    input  logic                      late_wb_yumi_i,

    output logic                      empty_o
);

    localparam int ptr_w_lp = $clog2(els_p);
    localparam int cnt_w_lp = $clog2(els_p + 1);
    localparam int age_w_lp = $clog2(force_age_p + 1);

    logic [wb_pkt_width_p-1:0] mem_q [els_p];
    logic [ptr_w_lp-1:0]       rptr_q, rptr_d;
    logic [ptr_w_lp-1:0]       wptr_q, wptr_d;
    logic [cnt_w_lp-1:0]       count_q, count_d;
    logic [age_w_lp-1:0]       age_q, age_d;
    logic                      last_grant_q, last_grant_d;

    logic                      full, store_empty, age_hit;
    logic                      mem_fire, fpu_fire, enq_v;
    logic [wb_pkt_width_p-1:0] enq_pkt;
    logic                      bypass_consume, wr_en, deq;

    assign full        = (count_q == cnt_w_lp'(els_p));
    assign store_empty = (count_q == '0);
    assign age_hit     = (age_q == age_w_lp'(force_age_p));

    // Round-robin: the source not granted last wins a tie.
    assign mem_ready_and_o = ~full & (~fpu_v_i | last_grant_q);
    assign fpu_ready_and_o = ~full & (~mem_v_i | ~last_grant_q);
    assign mem_fire        = mem_v_i & mem_ready_and_o;
    assign fpu_fire        = fpu_v_i & fpu_ready_and_o;
    assign enq_v           = mem_fire | fpu_fire;
    assign enq_pkt         = mem_fire ? mem_pkt_i : fpu_pkt_i;

`ifdef BP_BE_LATE_WB_BYPASS_EN
    assign late_wb_v_o    = ~store_empty | enq_v;
    assign late_wb_pkt_o  = store_empty ? enq_pkt : mem_q[rptr_q];
    assign bypass_consume = store_empty & late_wb_yumi_i;
    assign empty_o        = store_empty & ~mem_v_i & ~fpu_v_i;
`else
    assign late_wb_v_o    = ~store_empty;
    assign late_wb_pkt_o  = mem_q[rptr_q];
    assign bypass_consume = 1'b0;
    assign empty_o        = store_empty;
`endif

    // A bypassed packet never has age or fullness behind it, so force stays low for it.
    assign late_wb_force_o = ~store_empty & (age_hit | full);

    assign wr_en = enq_v & ~bypass_consume;
    assign deq   = late_wb_yumi_i & ~store_empty;

    always_comb begin
        rptr_d       = rptr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        age_d        = age_q;
        last_grant_d = last_grant_q;

        if (enq_v) last_grant_d = fpu_fire;
        if (wr_en) wptr_d = wptr_q + ptr_w_lp'(1);
        if (deq)   rptr_d = rptr_q + ptr_w_lp'(1);

        case ({wr_en, deq})
            2'b10:   count_d = count_q + cnt_w_lp'(1);
            2'b01:   count_d = count_q - cnt_w_lp'(1);
            default: count_d = count_q;
        endcase

        if (store_empty || deq) age_d = '0;
        else if (!age_hit)      age_d = age_q + age_w_lp'(1);
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rptr_q       <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            age_q        <= '0;
            last_grant_q <= 1'b1;
        end else begin
            rptr_q       <= rptr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            age_q        <= age_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Payload storage needs no reset: it is only observed while the count says it is valid.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q] <= enq_pkt;
    end

endmodule

// File: tb/tb_bp_be_late_wb_queue.sv
`timescale 1ns/1ps
// Directed bench for bp_be_late_wb_queue (els_p=4, force_age_p=8, 8-bit packets).
module tb_bp_be_late_wb_queue;

    logic       clk_i = 1'b0;
    logic       reset_n_i = 1'b0;
    logic       mem_v_i = 1'b0, fpu_v_i = 1'b0, late_wb_yumi_i = 1'b0;
    logic [7:0] mem_pkt_i = '0, fpu_pkt_i = '0;
    logic       mem_ready_and_o, fpu_ready_and_o;
    logic       late_wb_v_o, late_wb_force_o, empty_o;
    logic [7:0] late_wb_pkt_o;

    int vectors = 0;
    int miscompares = 0;

    bp_be_late_wb_queue #(.wb_pkt_width_p(8), .els_p(4), .force_age_p(8)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .mem_v_i(mem_v_i), .mem_pkt_i(mem_pkt_i), .mem_ready_and_o(mem_ready_and_o),
        .fpu_v_i(fpu_v_i), .fpu_pkt_i(fpu_pkt_i), .fpu_ready_and_o(fpu_ready_and_o),
        .late_wb_v_o(late_wb_v_o), .late_wb_pkt_o(late_wb_pkt_o),
        .late_wb_force_o(late_wb_force_o), .late_wb_yumi_i(late_wb_yumi_i),
        .empty_o(empty_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are set here, checks follow a #1 settle.
    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        mem_v_i = 0; fpu_v_i = 0; late_wb_yumi_i = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        #3 reset_n_i = 0;
        #12 reset_n_i = 1;
    endtask

    initial begin
        // Reset state
        #22 reset_n_i = 1;
        nxt(); #1;
        chk("rst_v", late_wb_v_o, 0);
        chk("rst_force", late_wb_force_o, 0);
        chk("rst_empty", empty_o, 1);
        chk("rst_mem_rdy", mem_ready_and_o, 1);
        chk("rst_fpu_rdy", fpu_ready_and_o, 1);

        // Single packet, aging to force
        nxt(); mem_v_i = 1; mem_pkt_i = 8'hA5; #1;
        chk("t1_accept_rdy", mem_ready_and_o, 1);
`ifdef BP_BE_LATE_WB_BYPASS_EN
        chk("t1_same_cycle_v", late_wb_v_o, 1);
        chk("t1_same_cycle_empty", empty_o, 0);
`else
        chk("t1_same_cycle_v", late_wb_v_o, 0);
        chk("t1_same_cycle_empty", empty_o, 1);
`endif
        nxt(); mem_v_i = 0; #1;
        chk("t1_v", late_wb_v_o, 1);
        chk("t1_pkt", late_wb_pkt_o, 8'hA5);
        chk("t1_force_age0", late_wb_force_o, 0);
        chk("t1_empty", empty_o, 0);
        for (int k = 1; k < 8; k++) begin
            nxt(); #1;
            chk($sformatf("t1_force_age%0d", k), late_wb_force_o, 0);
        end
        nxt(); late_wb_yumi_i = 1; #1;
        chk("t1_force_age8", late_wb_force_o, 1);
        chk("t1_pkt_age8", late_wb_pkt_o, 8'hA5);
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t1_empty_after", empty_o, 1);
        chk("t1_v_after", late_wb_v_o, 0);
        chk("t1_force_after", late_wb_force_o, 0);

        // Round-robin from reset: mem, fpu, mem, fpu
        do_reset();
        for (int i = 0; i < 4; i++) begin
            nxt();
            mem_v_i = 1; fpu_v_i = 1;
            mem_pkt_i = 8'h10 + 8'(i); fpu_pkt_i = 8'h20 + 8'(i);
            late_wb_yumi_i = (i != 0);
            #1;
            chk($sformatf("t2_mem_rdy%0d", i), mem_ready_and_o, (i % 2 == 0));
            chk($sformatf("t2_fpu_rdy%0d", i), fpu_ready_and_o, (i % 2 == 1));
            if (i == 1) chk("t2_head1", late_wb_pkt_o, 8'h10);
            if (i == 2) chk("t2_head2", late_wb_pkt_o, 8'h21);
            if (i == 3) chk("t2_head3", late_wb_pkt_o, 8'h12);
        end
        nxt(); mem_v_i = 0; fpu_v_i = 0; late_wb_yumi_i = 1; #1;
        chk("t2_head4", late_wb_pkt_o, 8'h23);
        chk("t2_v4", late_wb_v_o, 1);
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t2_empty", empty_o, 1);

        // Fill to full, then no passthrough on a yumi cycle
        for (int i = 0; i < 4; i++) begin
            nxt(); mem_v_i = 1; mem_pkt_i = 8'h30 + 8'(i); #1;
            chk($sformatf("t3_fill_rdy%0d", i), mem_ready_and_o, 1);
        end
        nxt(); mem_pkt_i = 8'h34; late_wb_yumi_i = 1; #1;
        chk("t3_full_mem_rdy", mem_ready_and_o, 0);
        chk("t3_full_fpu_rdy", fpu_ready_and_o, 0);
        chk("t3_full_force", late_wb_force_o, 1);
        chk("t3_full_head", late_wb_pkt_o, 8'h30);
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t3_retry_rdy", mem_ready_and_o, 1);
        chk("t3_retry_head", late_wb_pkt_o, 8'h31);
        chk("t3_retry_force", late_wb_force_o, 0);
        nxt(); mem_v_i = 0; #1;
        chk("t3_refull_force", late_wb_force_o, 1);
        chk("t3_refull_rdy", mem_ready_and_o, 0);
        for (int i = 0; i < 4; i++) begin
            if (i != 0) nxt();
            late_wb_yumi_i = 1; #1;
            chk($sformatf("t3_drain%0d", i), late_wb_pkt_o, 8'h31 + 8'(i));
        end
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t3_empty", empty_o, 1);

        // Streaming with pointer wrap: occupancy stays at one
        nxt(); mem_v_i = 1; mem_pkt_i = 8'h40; #1;
        for (int i = 1; i < 20; i++) begin
            nxt(); mem_pkt_i = 8'h40 + 8'(i); late_wb_yumi_i = 1; #1;
            chk($sformatf("t4_head%0d", i), late_wb_pkt_o, 8'h40 + 8'(i - 1));
            chk($sformatf("t4_rdy%0d", i), mem_ready_and_o, 1);
            if (i == 10) chk("t4_force_mid", late_wb_force_o, 0);
        end
        nxt(); mem_v_i = 0; #1;
        chk("t4_last", late_wb_pkt_o, 8'h53);
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t4_empty", empty_o, 1);

        // Same-cycle presentation when empty
        nxt(); fpu_v_i = 1; fpu_pkt_i = 8'h3C; late_wb_yumi_i = 1; #1;
`ifdef BP_BE_LATE_WB_BYPASS_EN
        chk("t5_v_now", late_wb_v_o, 1);
        chk("t5_pkt_now", late_wb_pkt_o, 8'h3C);
        nxt(); idle_inputs(); #1;
        chk("t5_v_next", late_wb_v_o, 0);
        chk("t5_empty_next", empty_o, 1);
`else
        chk("t5_v_now", late_wb_v_o, 0);
        nxt(); idle_inputs(); #1;
        chk("t5_v_next", late_wb_v_o, 1);
        chk("t5_pkt_next", late_wb_pkt_o, 8'h3C);
        late_wb_yumi_i = 1;
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t5_empty_after", empty_o, 1);
`endif

        // Asynchronous reset with three packets held
        for (int i = 0; i < 3; i++) begin
            nxt(); mem_v_i = 1; mem_pkt_i = 8'h60 + 8'(i); #1;
        end
        nxt(); mem_v_i = 0; #1;
        chk("t6_pre_head", late_wb_pkt_o, 8'h60);
        #2 reset_n_i = 0; #1;
        chk("t6_rst_v", late_wb_v_o, 0);
        chk("t6_rst_empty", empty_o, 1);
        chk("t6_rst_force", late_wb_force_o, 0);
        #10 reset_n_i = 1;
        nxt(); mem_v_i = 1; mem_pkt_i = 8'h70; #1;
        nxt(); mem_v_i = 0; late_wb_yumi_i = 1; #1;
        chk("t6_new_v", late_wb_v_o, 1);
        chk("t6_new_pkt", late_wb_pkt_o, 8'h70);
        nxt(); late_wb_yumi_i = 0; #1;
        chk("t6_no_stale", empty_o, 1);
        chk("t6_no_stale_v", late_wb_v_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

endmodule
